serial_sub: RTL and testbench

Bit-serial ripple-borrow subtractor computing `A - B` for unsigned `WIDTH`-bit operands. It processes one bit per clock, LSB first, through a single full-subtractor cell and a registered borrow. It trades latency for area and is the subtract-direction counterpart of the combinational ripple-carry adder chain in the arithmetic datapath. A start/busy/done handshake sequences each operation, and the result is held until the next operation completes.

---
 rtl/sub_pkg.sv | 17 +
 rtl/full_sub.sv | 26 ++
 rtl/serial_sub.sv | 105 ++++++++++
 tb/tb_serial_sub.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package sub_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } sub_state_t;

    // Bit-counter width: enough to count WIDTH steps, never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/full_sub.sv
// One-bit full subtractor: diff = A - B - borrow_in, built from two
// half-subtractors whose borrows are OR-ed together.
module full_sub (
    input  logic A,
    input  logic B,
    input  logic borrow_in,
    output logic diff,
    output logic borrow_out
);

    logic hs1_diff;
    logic hs1_borrow;
    logic hs2_borrow;

    // First half-subtractor handles A - B.
    assign hs1_diff   = A ^ B;
    assign hs1_borrow = ~A & B;

    // Second half-subtractor removes the incoming borrow from that difference.
    assign diff       = hs1_diff ^ borrow_in;
    assign hs2_borrow = ~hs1_diff & borrow_in;

    // A borrow out of either stage is a borrow out of the bit.
    assign borrow_out = hs1_borrow | hs2_borrow;

endmodule

// File: rtl/serial_sub.sv
// Bit-serial ripple-borrow subtractor: computes a - b one bit per clock,
// LSB first, through a single full_sub cell and a registered borrow.
module serial_sub
    import sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int              CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    // Reject operand widths the counter and shift logic are not meant for.
    if (WIDTH < 2 || WIDTH > 32) begin : g_width_check
        $error("serial_sub: WIDTH must be between 2 and 32");
    end

    sub_state_t       state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [CNT_W-1:0] cnt;
    logic             br;

    // The partial result keeps only the upper WIDTH-1 bits of the shift
    // window; the lowest bit falls out on the final shift straight into diff.
    logic [WIDTH-2:0] pr;
    logic [WIDTH-1:0] pr_next;

    logic cell_diff;
    logic cell_borrow;

    full_sub u_cell (
        .diff       (cell_diff),
        .borrow_out (cell_borrow),
        .borrow_in  (br),
        .A          (sa[0]),
        .B          (sb[0])
    );

    // New result bit enters at the MSB while earlier bits move toward the LSB.
    assign pr_next = {cell_diff, pr};

    // Sequencing FSM with the datapath registers and registered busy/done decodes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sa     <= '0;
            sb     <= '0;
            pr     <= '0;
            cnt    <= '0;
            br     <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        cnt   <= '0;
                        br    <= 1'b0;
                        state <= RUN;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end
                end
                RUN: begin
                    sa  <= {1'b0, sa[WIDTH-1:1]};
                    sb  <= {1'b0, sb[WIDTH-1:1]};
                    pr  <= pr_next[WIDTH-1:1];
                    br  <= cell_borrow;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        diff   <= pr_next;
                        borrow <= cell_borrow;
                        state  <= DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
// Scoreboard bench for serial_sub: a 4-bit instance for directed vectors and
// an 8-bit instance for a random sweep against a reference subtraction.
module tb_serial_sub;

    localparam int W4 = 4;
    localparam int W8 = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic          start4 = 1'b0;
    logic [W4-1:0] a4 = '0;
    logic [W4-1:0] b4 = '0;
    logic          busy4;
    logic          done4;
    logic [W4-1:0] diff4;
    logic          borrow4;

    logic          start8 = 1'b0;
    logic [W8-1:0] a8 = '0;
    logic [W8-1:0] b8 = '0;
    logic          busy8;
    logic          done8;
    logic [W8-1:0] diff8;
    logic          borrow8;

    serial_sub #(.WIDTH(W4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .diff(diff4), .borrow(borrow4)
    );

    serial_sub #(.WIDTH(W8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8)
    );

    always #5 clk = ~clk;

    // Counts rising edges; read at falling edges as "edges seen so far".
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W4:0] val;
        int          cyc;
    } exp4_t;

    typedef struct {
        logic [W8:0] val;
        int          cyc;
    } exp8_t;

    exp4_t q4[$];
    exp8_t q8[$];

    // First edge at which each instance can accept a new start again.
    int ok4 = 0;
    int ok8 = 0;
    int n_acc8 = 0;

    int n_compared = 0;
    int n_mismatched = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] required);
        n_compared++;
        if (actual !== required) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, required, $time);
        end
    endtask

    function automatic logic [W4:0] ref4(input logic [W4-1:0] a, input logic [W4-1:0] b);
        return {1'b0, a} - {1'b0, b};
    endfunction

    function automatic logic [W8:0] ref8(input logic [W8-1:0] a, input logic [W8-1:0] b);
        return {1'b0, a} - {1'b0, b};
    endfunction

    // Drive one cycle of the 4-bit instance; expected {borrow,diff} given by caller.
    task automatic applyStimulus(input logic s, input logic [W4-1:0] a, input logic [W4-1:0] b,
                                 input logic [W4:0] exp_val);
        @(negedge clk);
        start4 = s;
        a4 = a;
        b4 = b;
        if (s && (cyc + 1 >= ok4)) begin
            q4.push_back('{exp_val, cyc + 1 + W4});
            ok4 = cyc + 1 + W4 + 1;
        end
    endtask

    // Drive one cycle of the 8-bit instance; expectation from the reference model.
    task automatic applyStimulus8(input logic s, input logic [W8-1:0] a, input logic [W8-1:0] b);
        @(negedge clk);
        start8 = s;
        a8 = a;
        b8 = b;
        if (s && (cyc + 1 >= ok8)) begin
            q8.push_back('{ref8(a, b), cyc + 1 + W8});
            ok8 = cyc + 1 + W8 + 1;
            n_acc8++;
        end
    endtask

    // Monitor for the 4-bit instance: pops the scoreboard on every done.
    int busy_run4 = 0;
    exp4_t e4;
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                checkOutput("busy_done_overlap4", {31'b0, busy4 & done4}, 32'd0);
                if (done4) begin
                    checkOutput("expected_pending4", {31'b0, q4.size() > 0}, 32'd1);
                    if (q4.size() > 0) begin
                        e4 = q4.pop_front();
                        checkOutput("diff4", {28'b0, diff4}, {28'b0, e4.val[W4-1:0]});
                        checkOutput("borrow4", {31'b0, borrow4}, {31'b0, e4.val[W4]});
                        checkOutput("done_cycle4", cyc, e4.cyc);
                        checkOutput("busy_len4", busy_run4, W4);
                    end
                end
                busy_run4 = busy4 ? busy_run4 + 1 : 0;
            end else begin
                busy_run4 = 0;
            end
        end
    end

    // Monitor for the 8-bit instance.
    exp8_t e8;
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && done8) begin
                checkOutput("expected_pending8", {31'b0, q8.size() > 0}, 32'd1);
                if (q8.size() > 0) begin
                    e8 = q8.pop_front();
                    checkOutput("diff8", {24'b0, diff8}, {24'b0, e8.val[W8-1:0]});
                    checkOutput("borrow8", {31'b0, borrow8}, {31'b0, e8.val[W8]});
                    checkOutput("done_cycle8", cyc, e8.cyc);
                end
            end
        end
    end

    initial begin
        int guard;
        logic [W4-1:0] ta;
        logic [W4-1:0] tb;

        // Reset state of both instances.
        repeat (3) @(negedge clk);
        checkOutput("rst_busy4", {31'b0, busy4}, 32'd0);
        checkOutput("rst_done4", {31'b0, done4}, 32'd0);
        checkOutput("rst_diff4", {28'b0, diff4}, 32'd0);
        checkOutput("rst_borrow4", {31'b0, borrow4}, 32'd0);
        checkOutput("rst_diff8", {24'b0, diff8}, 32'd0);
        checkOutput("rst_busy8", {31'b0, busy8}, 32'd0);
        rst_n = 1'b1;

        // Basic operation: 9 - 7.
        applyStimulus(1'b1, 4'b1001, 4'b0111, 5'b0_0010);
        repeat (6) applyStimulus(1'b0, 4'h0, 4'h0, 5'h0);

        // Borrow cases and equal operands.
        applyStimulus(1'b1, 4'd7, 4'd9, 5'b1_1110);
        repeat (5) applyStimulus(1'b0, 4'h0, 4'h0, 5'h0);
        applyStimulus(1'b1, 4'd0, 4'd1, 5'b1_1111);
        repeat (5) applyStimulus(1'b0, 4'h0, 4'h0, 5'h0);
        applyStimulus(1'b1, 4'd15, 4'd15, 5'b0_0000);
        repeat (5) applyStimulus(1'b0, 4'h0, 4'h0, 5'h0);

        // Back-to-back: second start lands in the DONE cycle.
        applyStimulus(1'b1, 4'd6, 4'd2, 5'b0_0100);
        repeat (4) applyStimulus(1'b0, 4'h0, 4'h0, 5'h0);
        applyStimulus(1'b1, 4'd3, 4'd5, 5'b1_1110);
        repeat (5) applyStimulus(1'b0, 4'h0, 4'h0, 5'h0);

        // Start held high with operands changing every cycle.
        for (int i = 0; i < 25; i++) begin
            ta = 4'(i * 3 + 1);
            tb = 4'(i * 5 + 2);
            applyStimulus(1'b1, ta, tb, ref4(ta, tb));
        end
        repeat (6) applyStimulus(1'b0, 4'h0, 4'h0, 5'h0);

        // Reset mid-RUN after a prior result of 2.
        applyStimulus(1'b1, 4'd9, 4'd7, 5'b0_0010);
        repeat (6) applyStimulus(1'b0, 4'h0, 4'h0, 5'h0);
        checkOutput("prior_diff4", {28'b0, diff4}, 32'd2);
        applyStimulus(1'b1, 4'd5, 4'd1, 5'b0_0100);
        applyStimulus(1'b0, 4'h0, 4'h0, 5'h0);
        applyStimulus(1'b0, 4'h0, 4'h0, 5'h0);
        @(posedge clk);
        #2;
        checkOutput("busy_before_rst4", {31'b0, busy4}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("async_busy4", {31'b0, busy4}, 32'd0);
        checkOutput("async_done4", {31'b0, done4}, 32'd0);
        checkOutput("async_diff4", {28'b0, diff4}, 32'd0);
        checkOutput("async_borrow4", {31'b0, borrow4}, 32'd0);
        q4.delete();
        ok4 = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 4'hF, 4'h1, 5'h0);
            checkOutput("idle_after_rst4", {31'b0, busy4}, 32'd0);
        end
        applyStimulus(1'b1, 4'd12, 4'd4, 5'b0_1000);
        repeat (6) applyStimulus(1'b0, 4'h0, 4'h0, 5'h0);

        // 8-bit random sweep with start held high.
        while (n_acc8 < 1000) begin
            applyStimulus8(1'b1, 8'($urandom), 8'($urandom));
        end
        repeat (12) applyStimulus8(1'b0, 8'h0, 8'h0);

        guard = 0;
        while ((q4.size() > 0 || q8.size() > 0) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("drain4", q4.size(), 32'd0);
        checkOutput("drain8", q8.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
